// File: rtl/approach_a_to_b.sv
`default_nettype none
// ============================================================================
// Module   : approach_a_to_b
// Purpose  : Moves a working value A toward a target B. A is raised in coarse
//            steps while it is below B, then lowered in fine steps while it
//            is above B, finishing with A <= B. The number of steps taken is
//            counted, with flags for "fine step applied" and "coarse step
//            saturated at the top of the range".
// Ports    : clk_i      - single clock, rising edge
//            reset_n_i  - synchronous, active-low reset
//            start_i    - begin an adjustment (looked at only in INI)
//            ack_i      - release the result (looked at only in DONE)
//            ain_i      - initial A value, unsigned W bits
//            bin_i      - target B value, unsigned W bits
//            a_o        - working / result register
//            count_o    - arithmetic steps performed (saturating)
//            flag_o     - at least one fine step was applied
//            ovf_o      - a coarse step saturated at 2^W-1
//            qi_o/qc_o/qf_o/qd_o - one-hot state: INI, COARSE, FINE, DONE
// Revision : 1.0 - initial release
// ============================================================================
module approach_a_to_b #(
  parameter int unsigned W      = 12,
  parameter int unsigned COARSE = 100,
  parameter int unsigned FINE   = 10,
  parameter int unsigned CW     = 8
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          start_i,
  input  logic          ack_i,
  input  logic [W-1:0]  ain_i,
  input  logic [W-1:0]  bin_i,
  output logic [W-1:0]  a_o,
  output logic [CW-1:0] count_o,
  output logic          flag_o,
  output logic          ovf_o,
  output logic          qi_o,
  output logic          qc_o,
  output logic          qf_o,
  output logic          qd_o
);

  // One-hot encoding: bit positions map directly onto the Q outputs.
  typedef enum logic [3:0] {
    S_INI    = 4'b0001,
    S_COARSE = 4'b0010,
    S_FINE   = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  localparam logic [W:0]    c_coarse_ext = (W+1)'(COARSE);
  localparam logic [W:0]    c_amax_ext   = {1'b0, {W{1'b1}}};
  localparam logic [W-1:0]  c_amax       = {W{1'b1}};
  localparam logic [W-1:0]  c_fine       = W'(FINE);
  localparam logic [CW-1:0] c_count_max  = {CW{1'b1}};
  localparam logic [CW-1:0] c_count_one  = CW'(1);

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [CW-1:0] count_q;
  logic          flag_q;
  logic          ovf_q;

  logic [W:0]    coarse_sum_d;
  logic [W-1:0]  fine_a_d;
  logic [CW-1:0] count_d;

  // Coarse sum carries one extra bit so overflow past 2^W-1 is visible.
  assign coarse_sum_d = {1'b0, a_q} + c_coarse_ext;

  // Fine step clamps at zero instead of wrapping when A < FINE.
  assign fine_a_d = (a_q >= c_fine) ? (a_q - c_fine) : '0;

  // Step counter sticks at its maximum.
  assign count_d = (count_q == c_count_max) ? count_q : (count_q + c_count_one);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= S_INI;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        S_INI: begin
          // Operands are captured every cycle so the last value before
          // Start is the one used; later changes are ignored.
          a_q     <= ain_i;
          b_q     <= bin_i;
          count_q <= '0;
          flag_q  <= 1'b0;
          ovf_q   <= 1'b0;
          if (start_i) begin
            state_q <= S_COARSE;
          end
        end

        S_COARSE: begin
          if (a_q == b_q) begin
            state_q <= S_DONE;
          end else if (a_q > b_q) begin
            state_q <= S_FINE;
          end else begin
            count_q <= count_d;
            if (coarse_sum_d > c_amax_ext) begin
              a_q     <= c_amax;
              ovf_q   <= 1'b1;
              state_q <= S_FINE;
            end else begin
              a_q <= coarse_sum_d[W-1:0];
            end
          end
        end

        S_FINE: begin
          if (a_q <= b_q) begin
            state_q <= S_DONE;
          end else begin
            a_q     <= fine_a_d;
            flag_q  <= 1'b1;
            count_q <= count_d;
          end
        end

        S_DONE: begin
          if (ack_i) begin
            state_q <= S_INI;
          end
        end

        default: begin
          state_q <= S_INI;
        end
      endcase
    end
  end

  assign a_o     = a_q;
  assign count_o = count_q;
  assign flag_o  = flag_q;
  assign ovf_o   = ovf_q;
  assign qi_o    = state_q[0];
  assign qc_o    = state_q[1];
  assign qf_o    = state_q[2];
  assign qd_o    = state_q[3];

endmodule
`default_nettype wire

// File: tb/tb_approach_a_to_b.sv
`default_nettype none
// ============================================================================
// Module   : tb_approach_a_to_b
// Purpose  : Self-checking bench for approach_a_to_b (W=12, COARSE=100,
//            FINE=10, CW=8). A behavioural model computes the expected
//            per-cycle A trajectory, final result, flags and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approach_a_to_b;

  localparam int MAXV     = 4095;
  localparam int COARSE_V = 100;
  localparam int FINE_V   = 10;
  localparam int CMAX     = 255;
  localparam int BOUND    = 2000;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        ack_i = 1'b0;
  logic [11:0] ain_i = '0;
  logic [11:0] bin_i = '0;
  logic [11:0] a_o;
  logic [7:0]  count_o;
  logic        flag_o, ovf_o, qi_o, qc_o, qf_o, qd_o;

  int errors = 0;
  int checks = 0;
  int q_exp[$];

  approach_a_to_b #(.W(12), .COARSE(100), .FINE(10), .CW(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .ack_i(ack_i),
    .ain_i(ain_i), .bin_i(bin_i), .a_o(a_o), .count_o(count_o),
    .flag_o(flag_o), .ovf_o(ovf_o),
    .qi_o(qi_o), .qc_o(qc_o), .qf_o(qf_o), .qd_o(qd_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: walk the rules with plain integers. Coarse phase raises A
  // while below B (saturating at MAXV), fine phase lowers it while above B.
  function automatic void model(input int ain, input int bin,
                                output int a_f, output int cnt,
                                output int fl, output int ov, output int cyc);
    int  a, n;
    bit  in_fine, fin;
    q_exp.delete();
    a = ain; n = 0; fl = 0; ov = 0; cyc = 0; in_fine = 0; fin = 0;
    while (!fin) begin
      cyc++;
      if (!in_fine) begin
        if (a == bin) fin = 1;
        else if (a > bin) in_fine = 1;
        else begin
          n++;
          if (a + COARSE_V > MAXV) begin a = MAXV; ov = 1; in_fine = 1; end
          else a = a + COARSE_V;
        end
      end else begin
        if (a <= bin) fin = 1;
        else begin a = (a >= FINE_V) ? a - FINE_V : 0; fl = 1; n++; end
      end
      q_exp.push_back(a);
    end
    a_f = a;
    cnt = (n > CMAX) ? CMAX : n;
  endfunction

  task automatic test_reset();
    reset_n_i = 1'b0; start_i = 1'b1; ack_i = 1'b1;
    ain_i = 12'd123; bin_i = 12'd456;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({qi_o, qc_o, qf_o, qd_o} !== 4'b1000) begin
      errors++; $display("FAIL reset_state q=%b expected 1000", {qi_o, qc_o, qf_o, qd_o});
    end
    checks++;
    if ({a_o, count_o, flag_o, ovf_o} !== 22'd0) begin
      errors++; $display("FAIL reset_regs a=%0d cnt=%0d flag=%0b ovf=%0b expected all 0",
                         a_o, count_o, flag_o, ovf_o);
    end
    start_i = 1'b0; ack_i = 1'b0; reset_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  // Runs one adjustment. Ack is held high and Ain/Bin scrambled while
  // adjusting (must be ignored); Start is held high while waiting in DONE.
  task automatic do_case(input string name, input int ain, input int bin,
                         input int ack_wait);
    int ea, ec, ef, eo, ecyc, cyc;
    bit trace_ok, onehot_ok;
    logic [11:0] ha; logic [7:0] hc; logic hf, ho;
    model(ain, bin, ea, ec, ef, eo, ecyc);
    ain_i = 12'(ain); bin_i = 12'(bin); start_i = 1'b1; ack_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; ack_i = 1'b1;
    ain_i = 12'($urandom); bin_i = 12'($urandom);
    checks++;
    if (qc_o !== 1'b1 || a_o !== 12'(ain)) begin
      errors++; $display("FAIL %s_enter qc=%0b a=%0d expected qc=1 a=%0d", name, qc_o, a_o, ain);
    end
    cyc = 0; trace_ok = 1; onehot_ok = 1;
    while (qd_o !== 1'b1 && cyc < BOUND) begin
      @(negedge clk_i);
      cyc++;
      start_i = 1'($urandom);
      if (!$onehot({qi_o, qc_o, qf_o, qd_o})) onehot_ok = 0;
      if (cyc <= q_exp.size() && a_o !== 12'(q_exp[cyc-1])) begin
        if (trace_ok) $display("FAIL %s_trace cycle %0d a=%0d expected %0d",
                               name, cyc, a_o, q_exp[cyc-1]);
        trace_ok = 0;
      end
    end
    ack_i = 1'b0; start_i = 1'b1;
    checks++;
    if (cyc !== ecyc) begin
      errors++; $display("FAIL %s_latency cycles=%0d expected %0d", name, cyc, ecyc);
    end
    if (cyc >= BOUND) begin
      reset_n_i = 1'b0; start_i = 1'b0; @(negedge clk_i); reset_n_i = 1'b1;
      return;
    end
    checks++;
    if (!trace_ok) errors++;
    checks++;
    if (!onehot_ok) begin errors++; $display("FAIL %s_onehot q not one-hot while adjusting expected one-hot", name); end
    checks++;
    if (a_o !== 12'(ea) || count_o !== 8'(ec) || flag_o !== 1'(ef) || ovf_o !== 1'(eo)) begin
      errors++;
      $display("FAIL %s_result a=%0d cnt=%0d flag=%0b ovf=%0b expected a=%0d cnt=%0d flag=%0b ovf=%0b",
               name, a_o, count_o, flag_o, ovf_o, ea, ec, ef, eo);
    end
    ha = a_o; hc = count_o; hf = flag_o; ho = ovf_o;
    repeat (ack_wait) @(negedge clk_i);
    checks++;
    if (qd_o !== 1'b1 || a_o !== 12'(ea) || count_o !== 8'(ec) || flag_o !== 1'(ef) || ovf_o !== 1'(eo)) begin
      errors++;
      $display("FAIL %s_hold qd=%0b a=%0d cnt=%0d expected qd=1 a=%0d cnt=%0d (was %0d/%0d/%0b/%0b)",
               name, qd_o, a_o, count_o, ea, ec, ha, hc, hf, ho);
    end
    start_i = 1'b0; ack_i = 1'b1;
    @(negedge clk_i);
    ack_i = 1'b0;
    checks++;
    if (qi_o !== 1'b1) begin
      errors++; $display("FAIL %s_ack q=%b expected 1000", name, {qi_o, qc_o, qf_o, qd_o});
    end
    @(negedge clk_i);
  endtask

  task automatic test_directed();
    do_case("up_then_fine", 150, 437, 0);
    do_case("equal", 200, 200, 1);
    do_case("above", 500, 475, 2);
    do_case("saturate", 4000, 4090, 0);
    do_case("clamp_zero", 5, 0, 5);
    do_case("count_sat", 4095, 0, 1);
    do_case("zero_zero", 0, 0, 0);
    do_case("max_max", 4095, 4095, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      int a, b;
      a = int'($urandom_range(0, MAXV));
      b = (i % 3 == 0) ? int'($urandom_range(0, MAXV))
                       : (a + int'($urandom_range(0, 60)) - 30 + MAXV + 1) % (MAXV + 1);
      do_case("random", a, b, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    logic [11:0] a_before;
    ain_i = 12'd150; bin_i = 12'd437; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    guard = 0;
    while (qf_o !== 1'b1 && guard < 50) begin @(negedge clk_i); guard++; end
    checks++;
    if (qf_o !== 1'b1) begin errors++; $display("FAIL rmid_reach_fine qf=%0b expected 1", qf_o); end
    @(negedge clk_i);
    a_before = a_o;
    reset_n_i = 1'b0; start_i = 1'b1; ack_i = 1'b1;
    #1;
    checks++;
    if (qf_o !== 1'b1 || a_o !== a_before) begin
      errors++; $display("FAIL rmid_no_async qf=%0b a=%0d expected qf=1 a=%0d", qf_o, a_o, a_before);
    end
    @(negedge clk_i);
    checks++;
    if ({qi_o, qc_o, qf_o, qd_o} !== 4'b1000 || a_o !== 12'd0 || count_o !== 8'd0 ||
        flag_o !== 1'b0 || ovf_o !== 1'b0) begin
      errors++; $display("FAIL rmid_cleared q=%b a=%0d cnt=%0d flag=%0b ovf=%0b expected 1000 0 0 0 0",
                         {qi_o, qc_o, qf_o, qd_o}, a_o, count_o, flag_o, ovf_o);
    end
    reset_n_i = 1'b1; start_i = 1'b0; ack_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (qi_o !== 1'b1 || a_o !== 12'd150) begin
      errors++; $display("FAIL rmid_idle qi=%0b a=%0d expected qi=1 a=150", qi_o, a_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
